// File: rtl/mixer_pkg.sv
// Shared pan/state encodings and the pan cycle order for the stereo voice mixer.
package mixer_pkg;

    localparam logic [1:0] PAN_OFF   = 2'b00;
    localparam logic [1:0] PAN_LEFT  = 2'b01;
    localparam logic [1:0] PAN_RIGHT = 2'b10;
    localparam logic [1:0] PAN_BOTH  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Button cycle: BOTH -> OFF -> LEFT -> RIGHT -> BOTH
    function automatic logic [1:0] pan_next(input logic [1:0] p);
        case (p)
            PAN_BOTH: return PAN_OFF;
            PAN_OFF:  return PAN_LEFT;
            PAN_LEFT: return PAN_RIGHT;
            default:  return PAN_BOTH;
        endcase
    endfunction

endpackage

// File: rtl/pan_state_bank.sv
// Per-voice 2-bit pan registers; one addressed voice advances per button pulse.
module pan_state_bank #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pan_button_i,
    input  logic [CH_W-1:0]     pan_sel_i,
    output logic [2*NUM_CH-1:0] pan_state_o
);
    import mixer_pkg::*;

    logic [2*NUM_CH-1:0] pan_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pan_q <= {NUM_CH{PAN_BOTH}};
        end else if (pan_button_i) begin
            pan_q[{pan_sel_i, 1'b0} +: 2] <= pan_next(pan_q[{pan_sel_i, 1'b0} +: 2]);
        end
    end

    assign pan_state_o = pan_q;

endmodule

// File: rtl/stereo_voice_mixer.sv
// Serial N-voice stereo mixer with per-voice pan and a valid/accept output pair.
// Define SATURATE_MIX_EN to clip the sums instead of scaling them down by CH_W bits.
module stereo_voice_mixer #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 16,
    parameter int CH_W     = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
    input  logic                         sample_valid,
    input  logic                         pan_button,
    input  logic [CH_W-1:0]              pan_sel,
    input  logic                         frame_accept,
    output logic [SAMPLE_W-1:0]          left_out,
    output logic [SAMPLE_W-1:0]          right_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic [2*NUM_CH-1:0]          pan_state,
    output logic [7:0]                   overrun_count
);
    import mixer_pkg::*;

    localparam int ACC_W = SAMPLE_W + CH_W;

    state_t                       state_q, state_d;
    logic [CH_W-1:0]              idx_q, idx_d;
    logic [NUM_CH*SAMPLE_W-1:0]   samp_q, samp_d;
    logic [2*NUM_CH-1:0]          snap_q, snap_d;
    logic signed [ACC_W-1:0]      acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0]      acc_r_q, acc_r_d;
    logic [SAMPLE_W-1:0]          left_q, left_d;
    logic [SAMPLE_W-1:0]          right_q, right_d;
    logic                         vld_q, vld_d;
    logic [7:0]                   ovr_q, ovr_d;

    logic signed [SAMPLE_W-1:0]   cur_s;
    logic signed [ACC_W-1:0]      cur_ext;

    pan_state_bank #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pan (
        .clk          (clk),
        .reset        (reset),
        .pan_button_i (pan_button),
        .pan_sel_i    (pan_sel),
        .pan_state_o  (pan_state)
    );

`ifdef SATURATE_MIX_EN
    function automatic logic [SAMPLE_W-1:0] scale_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {{(CH_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
        min_v = {{(CH_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
        if (a > max_v)      return max_v[SAMPLE_W-1:0];
        else if (a < min_v) return min_v[SAMPLE_W-1:0];
        else                return a[SAMPLE_W-1:0];
    endfunction
`else
    // Dividing by NUM_CH keeps any all-voice full-scale sum representable.
    function automatic logic [SAMPLE_W-1:0] scale_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> CH_W;
        return sh[SAMPLE_W-1:0];
    endfunction
`endif

    assign cur_s   = samp_q[idx_q*SAMPLE_W +: SAMPLE_W];
    assign cur_ext = {{CH_W{cur_s[SAMPLE_W-1]}}, cur_s};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        samp_d  = samp_q;
        snap_d  = snap_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        left_d  = left_q;
        right_d = right_q;
        vld_d   = vld_q;
        ovr_d   = ovr_q;

        if (frame_accept && vld_q) vld_d = 1'b0;

        if (sample_valid && (state_q != ST_IDLE) && (ovr_q != 8'hFF))
            ovr_d = ovr_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    samp_d  = sample_in;
                    snap_d  = pan_state;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (snap_q[{idx_q, 1'b0}]) acc_l_d = acc_l_q + cur_ext;
                if (snap_q[{idx_q, 1'b1}]) acc_r_d = acc_r_q + cur_ext;
                idx_d = idx_q + 1'b1;
                if (idx_q == CH_W'(NUM_CH - 1)) state_d = ST_OUT;
            end
            ST_OUT: begin
                left_d  = scale_out(acc_l_q);
                right_d = scale_out(acc_r_q);
                vld_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            samp_q  <= '0;
            snap_q  <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            samp_q  <= samp_d;
            snap_q  <= snap_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            left_q  <= left_d;
            right_q <= right_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign left_out      = left_q;
    assign right_out     = right_q;
    assign out_valid     = vld_q;
    assign busy          = (state_q != ST_IDLE);
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_stereo_voice_mixer.sv
// Directed bench for stereo_voice_mixer with a scoreboard of expected mixes.
module tb_stereo_voice_mixer;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 16;
    localparam int CH_W     = 2;

    logic                        clk = 1'b0;
    logic                        reset = 1'b0;
    logic [NUM_CH*SAMPLE_W-1:0]  sample_in = '0;
    logic                        sample_valid = 1'b0;
    logic                        pan_button = 1'b0;
    logic [CH_W-1:0]             pan_sel = '0;
    logic                        frame_accept = 1'b0;
    logic [SAMPLE_W-1:0]         left_out;
    logic [SAMPLE_W-1:0]         right_out;
    logic                        out_valid;
    logic                        busy;
    logic [2*NUM_CH-1:0]         pan_state;
    logic [7:0]                  overrun_count;

    stereo_voice_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .pan_button    (pan_button),
        .pan_sel       (pan_sel),
        .frame_accept  (frame_accept),
        .left_out      (left_out),
        .right_out     (right_out),
        .out_valid     (out_valid),
        .busy          (busy),
        .pan_state     (pan_state),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic        busy_prev = 1'b0;
    logic [7:0]  pan_m = 8'hFF;
    int          cur[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock; on the edge where busy drops the DUT has written a mix.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (busy_prev && !busy) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("mix_left", left_out, e.l);
                chk("mix_right", right_out, e.r);
                chk("mix_valid", out_valid, 1);
            end
        end
        busy_prev = busy;
    endtask

    function automatic exp_t model();
        exp_t e;
        int sl, sr;
        sl = 0;
        sr = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (pan_m[2*k])   sl += cur[k];
            if (pan_m[2*k+1]) sr += cur[k];
        end
`ifdef SATURATE_MIX_EN
        if (sl > 32767) sl = 32767;
        if (sl < -32768) sl = -32768;
        if (sr > 32767) sr = 32767;
        if (sr < -32768) sr = -32768;
`else
        sl = sl >>> CH_W;
        sr = sr >>> CH_W;
`endif
        e.l = 16'(sl);
        e.r = 16'(sr);
        return e;
    endfunction

    task automatic send(input int s0, input int s1, input int s2, input int s3, input bit drop);
        cur[0] = s0; cur[1] = s1; cur[2] = s2; cur[3] = s3;
        for (int k = 0; k < NUM_CH; k++) sample_in[k*SAMPLE_W +: SAMPLE_W] = 16'(cur[k]);
        sample_valid = 1'b1;
        if (!drop) sb.push_back(model());
        cyc();
        sample_valid = 1'b0;
    endtask

    task automatic press(input int ch);
        logic [1:0] p;
        pan_sel = CH_W'(ch);
        pan_button = 1'b1;
        p = pan_m[2*ch +: 2];
        case (p)
            2'b11:   p = 2'b00;
            2'b00:   p = 2'b01;
            2'b01:   p = 2'b10;
            default: p = 2'b11;
        endcase
        pan_m[2*ch +: 2] = p;
        cyc();
        pan_button = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) cyc();
        chk("rst_left", left_out, 0);
        chk("rst_right", right_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pan", pan_state, 8'hFF);
        chk("rst_ovr", overrun_count, 0);

        // Basic mix, all BOTH, with busy window
        send(1000, 2000, 3000, 4000, 1'b0);
        chk("busy_c1", busy, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("busy_c2_5", busy, 1);
        end
        cyc();
        chk("busy_end", busy, 0);
        chk("basic_left", left_out, 16'd2500);
        chk("basic_right", right_out, 16'd2500);
        chk("basic_valid", out_valid, 1);

        frame_accept = 1'b1;
        cyc();
        chk("accept_clear", out_valid, 0);
        cyc();
        chk("accept_idle_ignored", out_valid, 0);
        chk("accept_idle_data", left_out, 16'd2500);
        frame_accept = 1'b0;

        press(0);
        chk("pan_off", pan_state, 8'hFC);
        press(0);
        chk("pan_left", pan_state, 8'hFD);
        send(1000, 2000, 3000, 4000, 1'b0);
        drain();
        chk("panl_left", left_out, 16'd2500);
        chk("panl_right", right_out, 16'd2250);
        press(0);
        press(0);
        chk("pan_restore", pan_state, 8'hFF);

        send(-32768, -32768, -32768, -32768, 1'b0);
        drain();
        chk("neg_full", left_out, 16'h8000);
        cyc();
        send(32767, 32767, 32767, 32767, 1'b0);
        drain();
        chk("pos_full", right_out, 16'h7FFF);
        cyc();
        send(10000, 10000, 0, 0, 1'b0);
        drain();
`ifdef SATURATE_MIX_EN
        chk("mid_mix", left_out, 16'd20000);
`else
        chk("mid_mix", left_out, 16'd5000);
`endif
        cyc();

        // Overrun: second strobe two cycles after capture is dropped
        send(400, 800, -1200, 4000, 1'b0);
        cyc();
        send(9, 9, 9, 9, 1'b1);
        drain();
        chk("ovr_count", overrun_count, 1);
        chk("ovr_keep_left", left_out, 16'd1000);
        cyc();

        // Accept coinciding with the OUT write keeps valid with new data
        send(-4000, 8000, 100, 300, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        frame_accept = 1'b1;
        cyc();
        frame_accept = 1'b0;
        chk("coincide_valid", out_valid, 1);
        chk("coincide_left", left_out, 16'd1100);
        frame_accept = 1'b1;
        cyc();
        frame_accept = 1'b0;
        chk("coincide_then_clear", out_valid, 0);

        // Reset mid-ACC
        press(1);
        chk("pan_ch1_off", pan_state, 8'hF3);
        send(1000, 1000, 1000, 1000, 1'b0);
        cyc();
        cyc();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_left", left_out, 0);
        chk("mid_rst_right", right_out, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pan", pan_state, 8'hFF);
        chk("mid_rst_ovr", overrun_count, 0);
        sb.delete();
        pan_m = 8'hFF;
        busy_prev = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cyc();
        send(-100, 200, -300, 1000, 1'b0);
        drain();
        chk("post_rst_left", left_out, 16'd200);
        chk("post_rst_valid", out_valid, 1);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stereo_voice_mixer.md
# stereo_voice_mixer

Parametrised N-voice stereo mixer between the music player's per-note sample outputs and the AC97 codec's left/right playback inputs. It replaces the single global mute-left/mute-right stereo control with a per-voice pan state cycled from a button. It sums the voices serially, one channel per cycle, into separate left and right accumulators. It holds the mixed pair for the codec with a valid/accept handshake.

## Interface
Parameters:
- NUM_CH, 4: number of voices; power of two, ≥2.
- SAMPLE_W, 16: signed sample width, input and output.
- CH_W, $clog2(NUM_CH): channel index width (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  NUM_CH*SAMPLE_W  voice samples; channel k at [k*SAMPLE_W +: SAMPLE_W], signed two's complement.
- sample_valid  in  1  one-cycle strobe: sample_in holds a new set.
- pan_button  in  1  one-cycle pulse, already debounced; advances the pan state of channel pan_sel.
- pan_sel  in  CH_W  channel addressed by pan_button.
- frame_accept  in  1  codec took the current left/right pair.
- left_out  out  SAMPLE_W  mixed left sample, registered.
- right_out  out  SAMPLE_W  mixed right sample, registered.
- out_valid  out  1  left_out/right_out hold an unaccepted mix.
- busy  out  1  high while not IDLE.
- pan_state  out  2*NUM_CH  current pan state per channel; channel k at [2k+1:2k].
- overrun_count  out  8  count of dropped sample_valid strobes; saturates at 255.

## Operation
- Pan encoding, 2 bits: bit0 = to left, bit1 = to right. OFF=00, LEFT=01, RIGHT=10, BOTH=11.
- Each pan_button pulse advances pan[pan_sel]: BOTH→OFF→LEFT→RIGHT→BOTH. Reset value is BOTH for every channel.
- Pan changes take effect on the next capture.
- State machine:
  - IDLE: on sample_valid, capture all NUM_CH samples and snapshot all pan states; clear both accumulators; idx=0; go to ACC.
  - ACC: if snap[idx][0], add sample[idx] to acc_l; if snap[idx][1], add it to acc_r; idx++. After idx=NUM_CH-1, go to OUT.
  - OUT: write left_out/right_out from the accumulators; set out_valid; go to IDLE.
- Accumulators are signed, SAMPLE_W+CH_W bits wide, and each input is sign-extended. Overflow of an accumulator is impossible by construction.
- Output scaling without the macro: arithmetic right shift by CH_W, keeping the low SAMPLE_W bits.
- sample_valid in ACC or OUT is dropped. overrun_count increments, saturating at 255, and the in-flight mix is unaffected.
- out_valid handshake:
  - Cleared on the edge after frame_accept while it is set.
  - frame_accept while out_valid=0 is ignored.
  - An OUT write coinciding with frame_accept leaves out_valid=1 with the new data.
  - An OUT write while out_valid is already 1 overwrites the data; there is no stall.

## Timing
- The capture edge is E0. Accumulate edges are E1..E_NUM_CH. Outputs and out_valid update at E_(NUM_CH+1). Latency is NUM_CH+1 cycles; 5 with defaults.
- busy is high from the edge after E0 through E_(NUM_CH+1).
- Minimum sample_valid spacing for no drop is NUM_CH+2 cycles.
- pan_state updates one edge after pan_button.
- Reset, asynchronous, any state: state=IDLE, idx=0, accumulators=0, left_out=right_out=0, out_valid=0, busy=0, pan=BOTH for all channels, overrun_count=0.
- Reset mid-ACC discards the partial mix.

## Configuration
- SATURATE_MIX_EN defined: no shift. Each accumulator is clipped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] at OUT.
- Not defined: the arithmetic right shift by CH_W, which preserves full-scale headroom.
- Latency is identical in both modes.

## Structure
- Package mixer_pkg holds:
  - the pan encoding constants PAN_OFF, PAN_LEFT, PAN_RIGHT, PAN_BOTH;
  - the state encoding ST_IDLE, ST_ACC, ST_OUT;
  - a pan_next function implementing the cycle order.
- Sub-module pan_state_bank contains the NUM_CH 2-bit pan registers with addressed advance and reset to BOTH. It outputs the packed pan_state vector.
- The mixer core contains the capture registers, FSM, accumulators, scaling/saturation, handshake and overrun counter.

## Test plan
Defaults are NUM_CH=4 and SAMPLE_W=16 unless noted.
- Reset, then observe 3 cycles → all outputs 0, pan_state=8'hFF, busy=0.
- Shift mode, samples {1000,2000,3000,4000} all BOTH → at E5 left_out=right_out=2500 and out_valid=1; busy high for cycles 1-5.
- Two pan_button pulses with pan_sel=0 (ch0 → LEFT), same samples → left_out=2500, right_out=2250; pan_state[1:0]=01.
- Four channels at -32768, then four at 32767, all BOTH:
  - shift mode → -32768, then 32767;
  - SATURATE_MIX_EN → clipped to -32768, then 32767;
  - a mix of {10000,10000,0,0} → 20000 with SATURATE_MIX_EN, 5000 without.
- sample_valid again 2 cycles after capture → dropped, overrun_count=1, output equals the first set's mix.
- frame_accept one cycle after out_valid rises → out_valid=0 next edge.
  - frame_accept on the OUT edge → out_valid stays 1 with the new data.
  - reset asserted mid-ACC → outputs 0 immediately, and the next capture mixes correctly.
